// File: rtl/mu0_cpu_param_if.sv
`default_nettype none
// ============================================================================
// Module      : mu0_cpu_param_if
// Description : Memory bus and OUT stream channel of the MU0 CPU.
// Revision    : 1.0 - initial release
// ============================================================================
interface mu0_cpu_param_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = DATA_WIDTH - 4
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  read;
   logic                  write;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  waitrequest;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;

   modport master (
      output address, read, write, writedata, out_valid, out_data,
      input  readdata, waitrequest, out_ready
   );

   modport slave (
      input  address, read, write, writedata, out_valid, out_data,
      output readdata, waitrequest, out_ready
   );
endinterface
`default_nettype wire

// File: rtl/mu0_cpu_param.sv
`default_nettype none
// ============================================================================
// Module      : mu0_cpu_param
// Description : Parametrised MU0 accumulator CPU with a stall-capable memory
//               port, valid/ready OUT channel and illegal-opcode trap.
// Revision    : 1.0 - initial release
// ============================================================================
module mu0_cpu_param #(
   parameter int                    DATA_WIDTH   = 16,
   parameter int                    ADDR_WIDTH   = DATA_WIDTH - 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            running,
   output logic            halt_illegal,
   mu0_cpu_param_if.master bus
);

   localparam logic [3:0] c_op_lda = 4'd0;
   localparam logic [3:0] c_op_sto = 4'd1;
   localparam logic [3:0] c_op_add = 4'd2;
   localparam logic [3:0] c_op_sub = 4'd3;
   localparam logic [3:0] c_op_jmp = 4'd4;
   localparam logic [3:0] c_op_jge = 4'd5;
   localparam logic [3:0] c_op_jne = 4'd6;
   localparam logic [3:0] c_op_stp = 4'd7;
   localparam logic [3:0] c_op_out = 4'd8;

   typedef enum logic [1:0] {
      S_FETCH    = 2'd0,
      S_EXEC     = 2'd1,
      S_OUT_WAIT = 2'd2,
      S_HALTED   = 2'd3
   } state_t;

   // Power-on value: the core idles until the first reset.
   state_t                r_state        = S_HALTED;
   logic                  r_halt_illegal = 1'b0;
   state_t                w_state_nx;
   logic                  w_halt_illegal_nx;
   logic [ADDR_WIDTH-1:0] r_pc, w_pc_nx;
   logic [DATA_WIDTH-1:0] r_acc, w_acc_nx;
   logic [DATA_WIDTH-1:0] r_instr, w_instr_nx;
   logic [DATA_WIDTH-1:0] r_out_data, w_out_data_nx;

   logic [3:0]            w_opcode;
   logic [ADDR_WIDTH-1:0] w_operand;
   logic [ADDR_WIDTH-1:0] w_pc_inc;
   logic                  w_exec;

   assign w_opcode  = r_instr[DATA_WIDTH-1 -: 4];
   assign w_operand = r_instr[ADDR_WIDTH-1:0];
   assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
   assign w_exec    = (r_state == S_EXEC);

   assign running       = (r_state != S_HALTED);
   assign halt_illegal  = r_halt_illegal;
   assign bus.read      = (r_state == S_FETCH) ||
                          (w_exec && (w_opcode == c_op_lda || w_opcode == c_op_add ||
                                      w_opcode == c_op_sub));
   assign bus.write     = w_exec && (w_opcode == c_op_sto);
   assign bus.address   = w_exec ? w_operand : r_pc;
   assign bus.writedata = r_acc;
   assign bus.out_valid = (r_state == S_OUT_WAIT);
   assign bus.out_data  = r_out_data;

   always_comb begin
      w_state_nx        = r_state;
      w_pc_nx           = r_pc;
      w_acc_nx          = r_acc;
      w_instr_nx        = r_instr;
      w_out_data_nx     = r_out_data;
      w_halt_illegal_nx = r_halt_illegal;
      unique case (r_state)
         S_FETCH: begin
            if (!bus.waitrequest) begin
               w_instr_nx = bus.readdata;
               w_state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            case (w_opcode)
               c_op_lda, c_op_add, c_op_sub, c_op_sto: begin
                  if (!bus.waitrequest) begin
                     if (w_opcode == c_op_lda) w_acc_nx = bus.readdata;
                     if (w_opcode == c_op_add) w_acc_nx = r_acc + bus.readdata;
                     if (w_opcode == c_op_sub) w_acc_nx = r_acc - bus.readdata;
                     w_pc_nx    = w_pc_inc;
                     w_state_nx = S_FETCH;
                  end
               end
               c_op_jmp: begin
                  w_pc_nx    = w_operand;
                  w_state_nx = S_FETCH;
               end
               c_op_jge: begin
                  w_pc_nx    = r_acc[DATA_WIDTH-1] ? w_pc_inc : w_operand;
                  w_state_nx = S_FETCH;
               end
               c_op_jne: begin
                  w_pc_nx    = (r_acc != '0) ? w_operand : w_pc_inc;
                  w_state_nx = S_FETCH;
               end
               c_op_stp: w_state_nx = S_HALTED;
               c_op_out: begin
                  w_out_data_nx = r_acc;
                  w_state_nx    = S_OUT_WAIT;
               end
               default: begin
                  w_halt_illegal_nx = 1'b1;
                  w_state_nx        = S_HALTED;
               end
            endcase
         end
         // Acceptance is only seen once the channel is actually presenting data.
         S_OUT_WAIT: begin
            if (bus.out_ready) begin
               w_pc_nx    = w_pc_inc;
               w_state_nx = S_FETCH;
            end
         end
         S_HALTED: begin
            w_state_nx = S_HALTED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_FETCH;
         r_pc           <= RESET_VECTOR;
         r_acc          <= '0;
         r_instr        <= '0;
         r_out_data     <= '0;
         r_halt_illegal <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_pc           <= w_pc_nx;
         r_acc          <= w_acc_nx;
         r_instr        <= w_instr_nx;
         r_out_data     <= w_out_data_nx;
         r_halt_illegal <= w_halt_illegal_nx;
      end
   end

endmodule
`default_nettype wire
